pipeline_stage: RTL and testbench

Parametrised, elastic pipeline register for the MIPS datapath. It replaces the fixed 32-bit, always-enabled stage registers with a WIDTH-bit stage that uses a valid/ready handshake and a two-entry skid buffer. The stage sustains one transfer per cycle under back-pressure, has a registered `in_ready`, and supports a synchronous flush for branch/hazard squash. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB; a stall is expressed by deasserting `out_ready` downstream.

---
 rtl/pipeline_stage.sv | 99 +++++++++
 tb/tb_pipeline_stage.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stage.sv
// Elastic WIDTH-bit pipeline register with valid/ready handshake,
// two-entry skid buffer, registered in_ready and synchronous flush.
module pipeline_stage #(
  parameter int unsigned          WIDTH       = 32,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             r_in_ready;
  logic             w_push;
  logic             w_pop;

  assign out_valid = (r_state != EMPTY);
  assign in_ready  = r_in_ready;
  assign out_data  = r_main;
  assign occupancy = r_state;

  assign w_push = in_valid & r_in_ready;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= EMPTY;
      r_main     <= RESET_VALUE;
      r_skid     <= RESET_VALUE;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_main     <= w_main_nxt;
      r_skid     <= w_skid_nxt;
      r_in_ready <= (w_state_nxt != FULL);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = RESET_VALUE;
      w_skid_nxt  = RESET_VALUE;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_push) begin
            w_main_nxt  = in_data;
            w_state_nxt = ONE;
          end
        end
        ONE: begin
          if (w_push && w_pop) begin
            w_main_nxt = in_data;
          end else if (w_push) begin
            w_skid_nxt  = in_data;
            w_state_nxt = FULL;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_main_nxt  = r_skid;
            w_state_nxt = ONE;
          end
        end
        default: begin
          // Unreachable encoding: recover to a clean empty stage
          w_state_nxt = EMPTY;
          w_main_nxt  = RESET_VALUE;
          w_skid_nxt  = RESET_VALUE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_stage.sv
// Directed bench for pipeline_stage: 32-bit default instance and
// a 5-bit instance with RESET_VALUE 5'h1F.
module tb_pipeline_stage;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  logic        flush5;
  logic        in_valid5;
  logic        in_ready5;
  logic [4:0]  in_data5;
  logic        out_valid5;
  logic        out_ready5;
  logic [4:0]  out_data5;
  logic [1:0]  occupancy5;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  pipeline_stage #(
    .WIDTH(32),
    .RESET_VALUE(32'h0)
  ) u_dut (
    .clock(clock),
    .reset_n(reset_n),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .occupancy(occupancy)
  );

  pipeline_stage #(
    .WIDTH(5),
    .RESET_VALUE(5'h1F)
  ) u_dut5 (
    .clock(clock),
    .reset_n(reset_n),
    .flush(flush5),
    .in_valid(in_valid5),
    .in_ready(in_ready5),
    .in_data(in_data5),
    .out_valid(out_valid5),
    .out_ready(out_ready5),
    .out_data(out_data5),
    .occupancy(occupancy5)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_st(input string tag,
                        input logic ov, input logic ir,
                        input logic [1:0] oc, input logic [31:0] od);
    chk({tag, "_ov"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, "_ir"}, {31'd0, in_ready}, {31'd0, ir});
    chk({tag, "_occ"}, {30'd0, occupancy}, {30'd0, oc});
    chk({tag, "_od"}, out_data, od);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nxt;
    int exp5;
    int cyc;
    reset_n    = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    flush5     = 1'b0;
    in_valid5  = 1'b0;
    in_data5   = '0;
    out_ready5 = 1'b0;
    #12;
    chk_st("rst0", 1'b0, 1'b1, 2'd0, 32'h0);
    chk("rst0_p5_od", {27'd0, out_data5}, 32'h1F);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // load one entry, then reset asynchronously mid-cycle
    in_valid = 1'b1;
    in_data  = 32'h55;
    step();
    in_valid = 1'b0;
    chk_st("pre_rst", 1'b1, 1'b1, 2'd1, 32'h55);
    #2;
    reset_n = 1'b0;
    #1;
    chk_st("async_rst", 1'b0, 1'b1, 2'd0, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    step();

    // streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      step();
      chk_st($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, i);
    end
    in_valid = 1'b0;
    step();
    chk("stream_drain_occ", {30'd0, occupancy}, 32'd0);

    // back-pressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    chk_st("bp_a", 1'b1, 1'b1, 2'd1, 32'hA);
    in_data = 32'hB;
    step();
    chk_st("bp_b", 1'b1, 1'b0, 2'd2, 32'hA);
    in_data = 32'hC;
    step();
    chk_st("bp_c_held", 1'b1, 1'b0, 2'd2, 32'hA);
    step();
    chk_st("bp_idle", 1'b1, 1'b0, 2'd2, 32'hA);
    out_ready = 1'b1;
    step();
    chk_st("bp_rel_b", 1'b1, 1'b1, 2'd1, 32'hB);
    step();
    chk_st("bp_rel_c", 1'b1, 1'b1, 2'd1, 32'hC);
    in_valid = 1'b0;
    step();
    chk_st("bp_empty", 1'b0, 1'b1, 2'd0, 32'hC);

    // flush from FULL with a same-cycle offer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    in_data = 32'h22;
    step();
    chk_st("fl_full", 1'b1, 1'b0, 2'd2, 32'h11);
    flush   = 1'b1;
    in_data = 32'h33;
    step();
    flush = 1'b0;
    chk_st("fl_after", 1'b0, 1'b1, 2'd0, 32'h0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk_st("fl_no33", 1'b0, 1'b1, 2'd0, 32'h0);

    // flush in ONE with accept+pop
    in_valid = 1'b1;
    in_data  = 32'h44;
    step();
    chk_st("fl1_one", 1'b1, 1'b1, 2'd1, 32'h44);
    flush   = 1'b1;
    in_data = 32'h66;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk_st("fl1_empty", 1'b0, 1'b1, 2'd0, 32'h0);

    // 5-bit instance: random back-pressure stream 0x00..0x1F
    nxt  = 0;
    exp5 = 0;
    cyc  = 0;
    while (exp5 < 32 && cyc < 2000) begin
      out_ready5 = 1'($urandom_range(0, 1));
      in_valid5  = (nxt < 32);
      in_data5   = nxt[4:0];
      if (out_valid5 && out_ready5) begin
        chk("p5_order", {27'd0, out_data5}, exp5);
        exp5++;
      end
      if (in_valid5 && in_ready5) nxt++;
      step();
      cyc++;
    end
    chk("p5_count", exp5, 32);
    in_valid5  = 1'b0;
    out_ready5 = 1'b0;
    step();
    chk("p5_empty_occ", {30'd0, occupancy5}, 32'd0);
    in_valid5 = 1'b1;
    in_data5  = 5'h03;
    step();
    in_valid5 = 1'b0;
    chk("p5_load_od", {27'd0, out_data5}, 32'h03);
    flush5 = 1'b1;
    step();
    flush5 = 1'b0;
    chk("p5_flush_od", {27'd0, out_data5}, 32'h1F);
    chk("p5_flush_ov", {31'd0, out_valid5}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
